// File: rtl/qspi_arb_pkg.sv
// Shared encodings for the icache/dcache to QSPI line arbiter.
// Holds the state encoding and the chip-select (q_mem) index constants.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  localparam logic [1:0] MEM_FLASH = 2'd0;
  localparam logic [1:0] MEM_RAM   = 2'd1;
  localparam logic [1:0] MEM_ALT   = 2'd2;

endpackage

// File: rtl/qspi_arb.sv
// Arbitrates icache fills and dcache fills/writebacks onto one QSPI line port.
// Optional macro QSPI_ARB_STARVE_EN adds a starvation guard that forces an I grant.
//
// state  | meaning
// IDLE   | no transfer; arbitrate pending requests
// BUSY_I | icache line transfer in flight, waiting for q_ack
// BUSY_D | dcache line transfer in flight, waiting for q_ack
// TURN   | one-cycle gap after q_ack; requests are not sampled
module qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4,
  parameter int STARVE_MAX  = 3,
  localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  output logic          d_done,
  input  logic [1:0]    rom_mode,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic [1:0]    q_mem,
  input  logic          q_ack,
  output logic          busy
);

  arb_state_e    state, state_nx;
  logic          q_req_nx, q_i_d_nx, q_write_nx;
  logic [TW-1:0] q_paddr_nx;
  logic [1:0]    q_mem_nx;
  logic          force_i;

  // a is the top physical address bit, i.e. the MSB of the line tag.
  function automatic logic [1:0] mem_decode(input logic [1:0] mode,
                                            input logic       a,
                                            input logic       i_or_pull);
    logic [1:0] m;
    case (mode)
      2'b00:   m = a ? MEM_ALT : MEM_FLASH;
      2'b01:   m = MEM_FLASH;
      2'b10:   m = a ? MEM_RAM : MEM_FLASH;
      default: m = i_or_pull ? MEM_RAM : MEM_FLASH;
    endcase
    return m;
  endfunction

  always_comb begin
    state_nx   = state;
    q_req_nx   = q_req;
    q_i_d_nx   = q_i_d;
    q_write_nx = q_write;
    q_paddr_nx = q_paddr;
    q_mem_nx   = q_mem;
    case (state)
      IDLE: begin
        if (d_req && !force_i) begin
          state_nx   = BUSY_D;
          q_req_nx   = 1'b1;
          q_i_d_nx   = 1'b0;
          q_write_nx = d_write;
          q_paddr_nx = d_tag;
          q_mem_nx   = mem_decode(rom_mode, d_tag[TW-1], !d_write);
        end else if (i_req) begin
          state_nx   = BUSY_I;
          q_req_nx   = 1'b1;
          q_i_d_nx   = 1'b1;
          q_write_nx = 1'b0;
          q_paddr_nx = i_tag;
          q_mem_nx   = mem_decode(rom_mode, i_tag[TW-1], 1'b1);
        end
      end
      BUSY_I, BUSY_D: begin
        if (q_ack) begin
          state_nx = TURN;
          q_req_nx = 1'b0;
        end
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      q_mem   <= MEM_FLASH;
    end else begin
      state   <= state_nx;
      q_req   <= q_req_nx;
      q_i_d   <= q_i_d_nx;
      q_write <= q_write_nx;
      q_paddr <= q_paddr_nx;
      q_mem   <= q_mem_nx;
    end
  end

  assign i_done = q_ack && (state == BUSY_I);
  assign d_done = q_ack && (state == BUSY_D);
  assign busy   = (state != IDLE);

`ifdef QSPI_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt, starve_nx;
  logic          grant_i, grant_d;

  assign grant_i = (state == IDLE) && (state_nx == BUSY_I);
  assign grant_d = (state == IDLE) && (state_nx == BUSY_D);

  // Counts D grants that overtook a waiting I request; saturates at STARVE_MAX.
  always_comb begin
    starve_nx = starve_cnt;
    if (grant_i || (state == IDLE && !i_req))
      starve_nx = '0;
    else if (grant_d && starve_cnt != SW'(STARVE_MAX))
      starve_nx = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else        starve_cnt <= starve_nx;
  end

  assign force_i = i_req && (starve_cnt == SW'(STARVE_MAX));
`else
  assign force_i = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_arb.sv
// Self-checking bench for qspi_arb: transaction-level reference model plus directed scenarios.
module tb_qspi_arb;

  localparam int PA = 24;
  localparam int LL = 4;
  localparam int SM = 3;
  localparam int TW = PA - $clog2(LL);
`ifdef QSPI_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk, reset;
  logic          i_req, d_req, d_write, q_ack;
  logic [TW-1:0] i_tag, d_tag;
  logic [1:0]    rom_mode;
  logic          i_done, d_done, q_req, q_i_d, q_write, busy;
  logic [TW-1:0] q_paddr;
  logic [1:0]    q_mem;

  int checks = 0;
  int errors = 0;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LL), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_done(d_done),
    .rom_mode(rom_mode),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_paddr(q_paddr),
    .q_mem(q_mem), .q_ack(q_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_mem(input int mode, input bit a, input bit side_i, input bit wr);
    case (mode)
      0:       return a ? 2 : 0;
      1:       return 0;
      2:       return a ? 1 : 0;
      default: return (side_i || !wr) ? 1 : 0;
    endcase
  endfunction

  // Reference model: who owns the port, whether we are in the post-ack gap,
  // and what was latched at grant time.
  int m_own;     // 0 none, 1 icache, 2 dcache
  bit m_gap;
  int m_paddr, m_mem, m_starve;
  bit m_write;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_own = 0; m_gap = 0; m_paddr = 0; m_mem = 0; m_write = 0; m_starve = 0;
    end else if (m_own != 0) begin
      if (q_ack) begin m_own = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      bit take_i;
      take_i = i_req && (!d_req || (STARVE && m_starve >= SM));
      if (take_i) begin
        m_own = 1; m_write = 0; m_paddr = int'(i_tag);
        m_mem = exp_mem(int'(rom_mode), i_tag[TW-1], 1'b1, 1'b0);
        m_starve = 0;
      end else if (d_req) begin
        m_own = 2; m_write = d_write; m_paddr = int'(d_tag);
        m_mem = exp_mem(int'(rom_mode), d_tag[TW-1], 1'b0, d_write);
        m_starve = i_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
      end else begin
        m_starve = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_own != 0 || m_gap));
    chk("q_req", int'(q_req), int'(m_own != 0));
    chk("i_done", int'(i_done), int'(q_ack && m_own == 1));
    chk("d_done", int'(d_done), int'(q_ack && m_own == 2));
    if (m_own != 0) begin
      chk("q_i_d", int'(q_i_d), int'(m_own == 1));
      chk("q_write", int'(q_write), int'(m_write));
      chk("q_paddr", int'(q_paddr), m_paddr);
      chk("q_mem", int'(q_mem), m_mem);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_qreq(input string name);
    int n = 0;
    while (!q_req && n < 20) begin tick(); n++; end
    chk({name, "_timeout"}, int'(q_req), 1);
  endtask

  // Ack the running transfer, drop both requests, and settle back to IDLE.
  task automatic ack_and_idle();
    q_ack = 1'b1;
    tick();
    q_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  int order[5];
  int exp_order[5];
  int mem_exp[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; i_req = 0; d_req = 0; d_write = 0; q_ack = 0;
    i_tag = '0; d_tag = '0; rom_mode = 2'b00;
    #2;
    chk("rst_q_req", int'(q_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q_paddr", int'(q_paddr), 0);
    chk("rst_q_mem", int'(q_mem), 0);
    chk("rst_q_i_d", int'(q_i_d) + int'(q_write) + int'(i_done) + int'(d_done), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single icache fill, q_ack 5 cycles after q_req.
    i_req = 1'b1; i_tag = 22'h12345; rom_mode = 2'b00;
    #1 chk("i_pre_q_req", int'(q_req), 0);
    tick();
    chk("i_q_req_plus1", int'(q_req), 1);
    chk("i_q_i_d", int'(q_i_d), 1);
    chk("i_q_paddr", int'(q_paddr), 32'h12345);
    chk("i_q_mem", int'(q_mem), 0);
    repeat (4) tick();
    q_ack = 1'b1;
    #1 chk("i_done_pulse", int'(i_done), 1);
    tick();
    q_ack = 1'b0; i_req = 1'b0;
    chk("i_turn_busy", int'(busy), 1);
    chk("i_turn_q_req", int'(q_req), 0);
    tick();
    chk("i_idle_busy", int'(busy), 0);

    // Simultaneous I and D; D wins, I follows after TURN. D holds req through TURN.
    i_req = 1'b1; i_tag = 22'h00ABC;
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h200055; rom_mode = 2'b11;
    tick();
    chk("both_d_first", int'(q_i_d), 0);
    chk("both_d_write", int'(q_write), 1);
    chk("both_d_mem", int'(q_mem), 0);
    tick();
    q_ack = 1'b1;
    #1 chk("both_d_done", int'(d_done), 1);
    tick();
    q_ack = 1'b0;
    tick();
    d_req = 1'b0;
    tick();
    chk("both_i_next", int'(q_i_d), 1);
    chk("both_i_mem", int'(q_mem), 1);
    ack_and_idle();

    // q_mem decode across rom_mode for a dcache pull with tag MSB set.
    mem_exp = '{2, 0, 1, 1};
    for (int m = 0; m < 4; m++) begin
      rom_mode = 2'(m); d_req = 1'b1; d_write = 1'b0; d_tag = 22'h3ABCDE;
      tick();
      chk($sformatf("mem_mode%0d", m), int'(q_mem), mem_exp[m]);
      ack_and_idle();
    end

    // Starvation scenario: i_req held, d_req always present.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    rom_mode = 2'b00; i_tag = 22'h00111; d_tag = 22'h00222; d_write = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    exp_order = STARVE ? '{2, 2, 2, 1, 2} : '{2, 2, 2, 2, 2};
    for (int g = 0; g < 5; g++) begin
      wait_qreq("starve_grant");
      order[g] = q_i_d ? 1 : 2;
      chk($sformatf("starve_order%0d", g), order[g], exp_order[g]);
      tick();
      q_ack = 1'b1;
      tick();
      q_ack = 1'b0;
      if (order[g] == 1) i_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Reset mid BUSY_D abandons the transfer; fresh grant after release.
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h0A5A5;
    tick();
    chk("rst_mid_busy_d", int'(q_req), 1);
    #2 reset = 1'b0;
    #1 chk("rst_mid_q_req", int'(q_req), 0);
    chk("rst_mid_busy", int'(busy), 0);
    q_ack = 1'b1;
    #1 chk("rst_mid_no_done", int'(d_done), 0);
    tick();
    q_ack = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_regrant", int'(q_req), 1);
    ack_and_idle();

    // d_req dropped mid BUSY_D; later a stray q_ack in IDLE.
    d_req = 1'b1; d_write = 1'b0; d_tag = 22'h01234; rom_mode = 2'b10;
    tick();
    d_req = 1'b0;
    repeat (3) tick();
    chk("drop_still_busy", int'(q_req), 1);
    q_ack = 1'b1;
    #1 chk("drop_d_done", int'(d_done), 1);
    tick();
    q_ack = 1'b0;
    tick();
    q_ack = 1'b1;
    #1 chk("stray_no_done", int'(d_done) + int'(i_done), 0);
    tick();
    q_ack = 1'b0;
    chk("stray_busy", int'(busy), 0);
    chk("stray_q_req", int'(q_req), 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
